// File: rtl/clock_fallback_monitor.sv
// Watches CHANNELS candidate clocks (as divide-by-2 toggles) and selects the highest-priority healthy one.
// Define CLOCK_FALLBACK_MONITOR_REVERT_EN to revert to a recovered higher-priority clock; otherwise selection is sticky.
module clock_fallback_monitor #(
  parameter int CHANNELS     = 4,
  parameter int STAGES       = 2,
  parameter int WINDOW       = 16,
  parameter int MIN_EDGES    = 2,
  parameter int GOOD_WINDOWS = 2,
  parameter int HOLDOFF      = 4,
  localparam int SEL_W = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] clock_toggles,
  input  logic [CHANNELS-1:0] enable_mask,
  output logic [CHANNELS-1:0] running,
  output logic [SEL_W-1:0]    select,
  output logic                select_valid,
  output logic                switch_pulse
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int EDGE_W = $clog2(MIN_EDGES + 1);
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  logic [STAGES-1:0]   sync_q [CHANNELS];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] edges;
  logic [CHANNELS-1:0] pass;
  logic [EDGE_W-1:0]   edge_q [CHANNELS];
  logic [EDGE_W-1:0]   edge_d [CHANNELS];
  logic [GOOD_W-1:0]   good_q [CHANNELS];
  logic [WIN_W-1:0]    win_q;
  logic                eval;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SEL_W-1:0]    select_d;
  logic                valid_d, pulse_d, take;
  logic [CHANNELS-1:0] eligible;
  logic [SEL_W-1:0]    pref;
  logic                sel_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= '0;
      for (int i = 0; i < CHANNELS; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][STAGES-2:0], clock_toggles[i]};
        prev_q[i] <= sync_q[i][STAGES-1];
      end
    end
  end

  // Edge counts saturate at MIN_EDGES; the evaluation-cycle edge is folded in before the pass test.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      edges[i]  = sync_q[i][STAGES-1] ^ prev_q[i];
      edge_d[i] = edge_q[i];
      if (edges[i] && (edge_q[i] != EDGE_W'(MIN_EDGES))) edge_d[i] = edge_q[i] + 1'b1;
      pass[i] = (edge_d[i] == EDGE_W'(MIN_EDGES));
    end
  end

  assign eval = (win_q == WIN_W'(WINDOW - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      win_q   <= '0;
      running <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        edge_q[i] <= '0;
        good_q[i] <= '0;
      end
    end else begin
      win_q <= eval ? '0 : win_q + 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (eval) begin
          edge_q[i] <= '0;
          if (pass[i]) begin
            if (good_q[i] != GOOD_W'(GOOD_WINDOWS)) good_q[i] <= good_q[i] + 1'b1;
            running[i] <= ((int'(good_q[i]) + 1) >= GOOD_WINDOWS);
          end else begin
            good_q[i]  <= '0;
            running[i] <= 1'b0;
          end
        end else begin
          edge_q[i] <= edge_d[i];
        end
      end
    end
  end

  always_comb begin
    eligible = running & enable_mask;
    pref     = '0;
    sel_ok   = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (eligible[i]) pref = SEL_W'(i);
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (select == SEL_W'(i)) sel_ok = eligible[i];
    end
  end

  // Loss of the selected clock overrides holdoff; reverts are only considered once holdoff has expired.
  always_comb begin
    state_d  = state_q;
    select_d = select;
    valid_d  = select_valid;
    pulse_d  = 1'b0;
    hold_d   = hold_q;
    take     = 1'b0;
    if (state_q == S_IDLE) begin
      take = |eligible;
    end else if (!(|eligible)) begin
      valid_d = 1'b0;
      pulse_d = 1'b1;
      state_d = S_IDLE;
    end else if (!sel_ok) begin
      take = 1'b1;
`ifdef CLOCK_FALLBACK_MONITOR_REVERT_EN
    end else if ((state_q == S_ACTIVE) && (pref < select)) begin
      take = 1'b1;
`endif
    end else if (state_q == S_HOLDOFF) begin
      if (hold_q == HOLD_W'(HOLDOFF - 1)) state_d = S_ACTIVE;
      else hold_d = hold_q + 1'b1;
    end
    if (take) begin
      select_d = pref;
      valid_d  = 1'b1;
      pulse_d  = 1'b1;
      state_d  = S_HOLDOFF;
      hold_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      select       <= '0;
      select_valid <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      select       <= select_d;
      select_valid <= valid_d;
      switch_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_clock_fallback_monitor.sv
// Randomized self-checking bench for clock_fallback_monitor against a window-arithmetic reference model.
module tb_clock_fallback_monitor;

  localparam int CH           = 4;
  localparam int STAGES       = 2;
  localparam int WINDOW       = 16;
  localparam int MIN_EDGES    = 2;
  localparam int GOOD_WINDOWS = 2;
  localparam int HOLDOFF      = 4;
`ifdef CLOCK_FALLBACK_MONITOR_REVERT_EN
  localparam bit REVERT = 1'b1;
`else
  localparam bit REVERT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] clock_toggles;
  logic [CH-1:0] enable_mask;
  logic [CH-1:0] running;
  logic [1:0]    select;
  logic          select_valid;
  logic          switch_pulse;

  always #5 clock = ~clock;

  clock_fallback_monitor #(
    .CHANNELS(CH), .STAGES(STAGES), .WINDOW(WINDOW), .MIN_EDGES(MIN_EDGES),
    .GOOD_WINDOWS(GOOD_WINDOWS), .HOLDOFF(HOLDOFF)
  ) dut (
    .clock(clock), .reset(reset), .clock_toggles(clock_toggles), .enable_mask(enable_mask),
    .running(running), .select(select), .select_valid(select_valid), .switch_pulse(switch_pulse)
  );

  int compare_count = 0;
  int mismatch_count = 0;
  int pulse_seen = 0;

  int half_period [CH];
  int toggle_cnt [CH];

  // Reference model: cycle index since reset, raw toggle history, per-window edge totals.
  int            n;
  logic [CH-1:0] history [$];
  int            win_edges [CH];
  int            streak [CH];
  logic [CH-1:0] m_run;
  int            m_sel;
  bit            m_valid;
  bit            m_pulse;
  int            last_switch;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit toggle_at(input int k, input int ch);
    if (k < 1) return 1'b0;
    return history[k][ch];
  endfunction

  task automatic modelStep();
    logic [CH-1:0] elig;
    int pref;
    bit do_switch;
    if (reset) begin
      n = 0;
      history = {};
      history.push_back('0);
      for (int i = 0; i < CH; i++) begin
        win_edges[i] = 0;
        streak[i] = 0;
      end
      m_run = '0;
      m_sel = 0;
      m_valid = 0;
      m_pulse = 0;
      last_switch = -1000;
      return;
    end
    elig = m_run & enable_mask;
    n++;
    history.push_back(clock_toggles);
    for (int i = 0; i < CH; i++)
      win_edges[i] += int'(toggle_at(n - STAGES, i) ^ toggle_at(n - STAGES - 1, i));
    if (n % WINDOW == 0) begin
      for (int i = 0; i < CH; i++) begin
        if (win_edges[i] >= MIN_EDGES) streak[i]++;
        else streak[i] = 0;
        m_run[i] = (streak[i] >= GOOD_WINDOWS);
        win_edges[i] = 0;
      end
    end
    pref = 0;
    for (int i = CH - 1; i >= 0; i--) if (elig[i]) pref = i;
    do_switch = 0;
    m_pulse = 0;
    if (!m_valid) do_switch = (elig != 0);
    else if (elig == 0) begin
      m_valid = 0;
      m_pulse = 1;
    end else if (!elig[m_sel]) do_switch = 1;
    else if (REVERT && (n - last_switch > HOLDOFF) && (pref < m_sel)) do_switch = 1;
    if (do_switch) begin
      m_sel = pref;
      m_valid = 1;
      m_pulse = 1;
      last_switch = n;
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock);
      #1;
      modelStep();
      checkOutput("running", 32'(running), 32'(m_run));
      checkOutput("select", 32'(select), 32'(m_sel));
      checkOutput("select_valid", 32'(select_valid), 32'(m_valid));
      checkOutput("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
      pulse_seen += int'(switch_pulse);
      for (int i = 0; i < CH; i++) begin
        if (half_period[i] != 0) begin
          toggle_cnt[i]++;
          if (toggle_cnt[i] >= half_period[i]) begin
            clock_toggles[i] = ~clock_toggles[i];
            toggle_cnt[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic setAllHalf(input int h);
    for (int i = 0; i < CH; i++) begin
      half_period[i] = h;
      toggle_cnt[i] = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    clock_toggles = '0;
    enable_mask = 4'b1111;
    setAllHalf(0);
    applyStimulus(3);
    checkOutput("reset_running", 32'(running), 32'd0);
    checkOutput("reset_select", 32'(select), 32'd0);
    checkOutput("reset_valid", 32'(select_valid), 32'd0);
    checkOutput("reset_pulse", 32'(switch_pulse), 32'd0);

    // All channels at clock/8 acquire within two windows.
    reset = 1'b0;
    setAllHalf(4);
    pulse_seen = 0;
    applyStimulus(40);
    checkOutput("acq_running", 32'(running), 32'hF);
    checkOutput("acq_select", 32'(select), 32'd0);
    checkOutput("acq_valid", 32'(select_valid), 32'd1);
    checkOutput("acq_pulses", 32'(pulse_seen), 32'd1);

    half_period[0] = 0;
    pulse_seen = 0;
    applyStimulus(40);
    checkOutput("loss_running0", 32'(running[0]), 32'd0);
    checkOutput("loss_select", 32'(select), 32'd1);
    checkOutput("loss_pulses", 32'(pulse_seen), 32'd1);

    half_period[0] = 4;
    toggle_cnt[0] = toggle_cnt[1];
    applyStimulus(60);
    checkOutput("recover_select", 32'(select), REVERT ? 32'd0 : 32'd1);

    setAllHalf(0);
    pulse_seen = 0;
    applyStimulus(50);
    checkOutput("dead_running", 32'(running), 32'd0);
    checkOutput("dead_valid", 32'(select_valid), 32'd0);
    checkOutput("dead_select", 32'(select), REVERT ? 32'd0 : 32'd1);
    checkOutput("dead_pulses", 32'(pulse_seen), 32'd1);

    setAllHalf(4);
    applyStimulus(60);
    checkOutput("reacq_select", 32'(select), 32'd0);
    checkOutput("reacq_valid", 32'(select_valid), 32'd1);
    enable_mask = 4'b1110;
    applyStimulus(1);
    checkOutput("mask_select", 32'(select), 32'd1);
    enable_mask = 4'b0000;
    applyStimulus(1);
    checkOutput("mask_none_valid", 32'(select_valid), 32'd0);

    enable_mask = 4'b1100;
    applyStimulus(5);
    checkOutput("mask_hi_select", 32'(select), 32'd2);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("midreset_running", 32'(running), 32'd0);
    checkOutput("midreset_select", 32'(select), 32'd0);
    checkOutput("midreset_valid", 32'(select_valid), 32'd0);
    reset = 1'b0;
    enable_mask = 4'b1111;
    pulse_seen = 0;
    applyStimulus(40);
    checkOutput("rst_reacq_running", 32'(running), 32'hF);
    checkOutput("rst_reacq_select", 32'(select), 32'd0);
    checkOutput("rst_reacq_pulses", 32'(pulse_seen), 32'd1);

    // Random toggle rates (clock/4 down to clock/24, or stuck), masks and occasional resets.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < CH; i++) begin
        int r;
        r = int'($urandom_range(0, 11));
        half_period[i] = (r == 0) ? 0 : r + 1;
      end
      enable_mask = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        applyStimulus(int'($urandom_range(1, 2)));
        reset = 1'b0;
      end
      applyStimulus(int'($urandom_range(20, 90)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
